// File: rtl/jtframe_ram_streamer_pkg.sv
// Local constants for the RAM streamer: FSM encoding and skid buffer depth.
package jtframe_ram_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/jtframe_stream_skid.sv
// Two-entry shift FIFO; entry 0 is always the head so dout is a plain register.
module jtframe_stream_skid #(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [dw-1:0] din,
    input  logic          pop,
    output logic [dw-1:0] dout,
    output logic [1:0]    occupancy
);
    logic [1:0]    occ_q, occ_d;
    logic [dw-1:0] mem0_q, mem0_d;
    logic [dw-1:0] mem1_q, mem1_d;

    always_comb begin
        occ_d  = occ_q;
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        mem0_d = din;
                        occ_d  = 2'd1;
                    end else if (occ_q == 2'd1) begin
                        mem1_d = din;
                        occ_d  = 2'd2;
                    end
                end
                2'b01: begin
                    mem0_d = mem1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (occ_q == 2'd1) begin
                        mem0_d = din;
                    end else if (occ_q == 2'd2) begin
                        mem0_d = mem1_q;
                        mem1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            mem0_q <= '0;
            mem1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
        end
    end

    assign dout      = mem0_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/jtframe_ram_streamer.sv
// Drains a block of RAM words into a valid/ready stream, hiding the RAM's
// one-cycle read latency behind a credit-controlled 2-entry skid buffer.
module jtframe_ram_streamer
    import jtframe_ram_streamer_pkg::*;
#(
    parameter int dw = 8,
    parameter int aw = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [aw-1:0] base,
    input  logic [aw:0]   len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [aw-1:0] ram_addr,
    input  logic [dw-1:0] ram_q,
    output logic [dw-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [1:0]    dbg_state
);
    // Stream handshake: a word transfers on any rising edge where out_valid and
    // out_ready are both high; once raised, out_valid/out_data/out_last hold until
    // that transfer (abort and reset excepted), and out_valid never waits on out_ready.

    state_t        state_q, state_d;
    logic [aw-1:0] rd_addr_q, rd_addr_d;
    logic [aw:0]   issue_cnt_q, issue_cnt_d;
    logic [aw:0]   beat_cnt_q, beat_cnt_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;

    logic [1:0]    occ;
    logic          pop, issue, flush, credit_ok;
    logic [2:0]    credit_used;

    assign pop         = out_valid & out_ready;
    assign flush       = abort & (state_q != ST_IDLE);
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok   = credit_used < 3'(SKID_DEPTH);
    assign issue       = (state_q == ST_RUN) && (issue_cnt_q != '0) && credit_ok && !abort;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = issue;
        done_d      = 1'b0;

        if (pop) beat_cnt_d = beat_cnt_q - 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        rd_addr_d   = base;
                        issue_cnt_d = len;
                        beat_cnt_d  = len;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rd_addr_d   = rd_addr_q + 1'b1;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                    if (issue_cnt_q == {{aw{1'b0}}, 1'b1}) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish on the edge of the final handshake so done follows it directly.
                if (beat_cnt_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

    jtframe_stream_skid #(.dw(dw)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (inflight_q),
        .din       (ram_q),
        .pop       (pop),
        .dout      (out_data),
        .occupancy (occ)
    );

    assign out_valid = (occ != 2'd0);
    assign out_last  = out_valid & (beat_cnt_q == {{aw{1'b0}}, 1'b1});
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ram_addr  = rd_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_jtframe_ram_streamer.sv
// Scoreboard bench for jtframe_ram_streamer: behavioural RAM, expected-word queue,
// stall stability and done/last timing checks.
module tb_jtframe_ram_streamer;
    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk, rst_n, start, abort, out_ready;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy, done, out_valid, out_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q, out_data;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, beats = 0, lasts = 0, done_cnt = 0, valid_cyc = 0;
    int last_cyc = 0, done_cyc = 0;
    bit ovf = 0, prev_stall = 0, prev_last = 0;
    logic [DW-1:0] prev_data;
    bit bp_mode = 0;
    int bp_idx = 0;
    bit bp_pat [6] = '{1, 0, 0, 1, 0, 1};

    jtframe_ram_streamer #(.dw(DW), .aw(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // back-pressure pattern driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = bp_pat[bp_idx % 6];
                bp_idx++;
            end
        end
    end

    // monitor + scoreboard
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (dut.occ > 2'd2) ovf = 1;
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                end
                if (out_valid) valid_cyc++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (out_valid && out_ready) begin
                    beats++;
                    if (out_last) begin
                        lasts++;
                        last_cyc = cyc;
                    end
                    if (exp_q.size() == 0) begin
                        check("extra_beat_qsize", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", out_data, e);
                        check("beat_last", out_last, exp_q.size() == 0);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_blk(input logic [AW-1:0] b, input logic [AW:0] n, input bit expect_beats);
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        start = 1;
        base  = b;
        len   = n;
        if (expect_beats) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + AW'(i);
                exp_q.push_back(mem[a]);
            end
        end
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check("done_seen", done_cnt != d0, 1);
    endtask

    initial begin
        int d0, b0, l0, v0;
        logic [AW-1:0] wexp [4];
        rst_n = 0; start = 0; abort = 0; out_ready = 1; base = '0; len = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom_range(0, 255));
        mem[10'h010] = 8'hAA; mem[10'h011] = 8'hBB; mem[10'h012] = 8'hCC; mem[10'h013] = 8'hDD;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_state", dbg_state, 0);

        // basic read
        d0 = done_cnt; b0 = beats; l0 = lasts;
        start_blk(10'h010, 11'd4, 1);
        tick();
        check("lat_c1_valid", out_valid, 0);
        check("lat_c1_addr", ram_addr, 10'h010);
        check("lat_c1_busy", busy, 1);
        tick();
        check("lat_c2_valid", out_valid, 0);
        tick();
        check("lat_c3_valid", out_valid, 1);
        check("first_data", out_data, 8'hAA);
        wait_done(d0, 20);
        check("basic_beats", beats - b0, 4);
        check("basic_lasts", lasts - l0, 1);
        check("basic_done_after_last", done_cyc - last_cyc, 1);
        check("basic_q_empty", exp_q.size(), 0);
        tick();
        check("basic_idle_busy", busy, 0);

        // wrap-around
        d0 = done_cnt; b0 = beats;
        wexp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        start_blk(10'h3FE, 11'd4, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wrap_addr", ram_addr, wexp[i]);
        end
        wait_done(d0, 20);
        check("wrap_beats", beats - b0, 4);
        check("wrap_q_empty", exp_q.size(), 0);

        // back-pressure with an ignored mid-block start
        d0 = done_cnt; b0 = beats; l0 = lasts;
        bp_idx = 0;
        bp_mode = 1;
        start_blk(10'h100, 11'd16, 1);
        repeat (5) tick();
        start_blk(10'h200, 11'd5, 0);
        check("bp_busy_after_ignored_start", busy, 1);
        wait_done(d0, 200);
        bp_mode = 0;
        out_ready = 1;
        check("bp_beats", beats - b0, 16);
        check("bp_lasts", lasts - l0, 1);
        check("bp_done_once", done_cnt - d0, 1);
        check("bp_q_empty", exp_q.size(), 0);
        repeat (3) tick();

        // zero length
        d0 = done_cnt; v0 = valid_cyc;
        start_blk(10'h050, 11'd0, 1);
        tick();
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (4) tick();
        check("zero_no_valid", valid_cyc - v0, 0);
        check("zero_done_once", done_cnt - d0, 1);

        // full range
        d0 = done_cnt; b0 = beats; l0 = lasts;
        start_blk(10'h155, 11'd1024, 1);
        wait_done(d0, 1200);
        check("full_beats", beats - b0, 1024);
        check("full_lasts", lasts - l0, 1);
        check("full_q_empty", exp_q.size(), 0);
        repeat (3) tick();
        check("full_done_once", done_cnt - d0, 1);

        // abort after the third beat
        d0 = done_cnt; b0 = beats;
        start_blk(10'h020, 11'd8, 1);
        for (int i = 0; i < 30 && (beats - b0) < 3; i++) tick();
        check("abort_reached_3", (beats - b0) >= 3, 1);
        @(posedge clk);
        #1 abort = 1;
        @(posedge clk);
        #1 abort = 0;
        exp_q.delete();
        v0 = valid_cyc;
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        repeat (5) tick();
        check("abort_no_valid", valid_cyc - v0, 0);
        check("abort_done_once", done_cnt - d0, 1);

        // asynchronous reset mid-block, then a fresh block
        start_blk(10'h010, 11'd8, 1);
        repeat (4) tick();
        rst_n = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_valid", out_valid, 0);
        check("arst_last", out_last, 0);
        check("arst_data", out_data, 0);
        check("arst_addr", ram_addr, 0);
        exp_q.delete();
        tick();
        rst_n = 1;
        tick();
        d0 = done_cnt; b0 = beats; l0 = lasts;
        start_blk(10'h010, 11'd4, 1);
        wait_done(d0, 20);
        check("post_rst_beats", beats - b0, 4);
        check("post_rst_lasts", lasts - l0, 1);
        check("post_rst_q_empty", exp_q.size(), 0);

        check("occ_overflow", ovf, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
